rgb_pixel_sender: RTL

//  Transmit side of the serial RGB-to-gray byte protocol. Accepts whole 24-bit

---
 rtl/rgb_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 50 +++++
 rtl/rgb_pixel_sender.sv | 116 +++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB pixel sender: FSM encoding and the
// byte-lane layout of a packed {R,G,B} pixel.
package rgb_pkg;
  localparam int PIX_W   = 24;
  localparam int COLOR_W = 8;
  localparam int R_MSB   = 23;
  localparam int G_MSB   = 15;
  localparam int B_MSB   = 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SEND_R = 3'd2,
    S_SEND_G = 3'd3,
    S_SEND_B = 3'd4,
    S_WAIT   = 3'd5,
    S_HOLD   = 3'd6
  } state_t;

  function automatic logic [COLOR_W-1:0] pix_byte(input logic [PIX_W-1:0] pix,
                                                  input int msb);
    return pix[msb -: COLOR_W];
  endfunction
endpackage

// File: rtl/pixel_fifo.sv
// DEPTH-entry synchronous FIFO holding whole pixels; a push is accepted while
// full when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rd];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end
endmodule

// File: rtl/rgb_pixel_sender.sv
// Buffers 24-bit pixels, serialises each as start + R,G,B bytes to the gray
// converter, and returns the converter's result on a valid/ready output.
module rgb_pixel_sender
  import rgb_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic [PIX_W-1:0]   pix_data_i,
  output logic               conv_start_o,
  output logic [COLOR_W-1:0] conv_color_o,
  input  logic               conv_valid_i,
  input  logic [COLOR_W-1:0] conv_gray_i,
  output logic               gray_valid_o,
  input  logic               gray_ready_i,
  output logic [COLOR_W-1:0] gray_data_o,
  output logic               timeout_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             r_state, w_next;
  logic [PIX_W-1:0]   r_pix, w_fifo_data;
  logic [TW-1:0]      r_cnt;
  logic [COLOR_W-1:0] r_gray;
  logic               r_gray_vld, r_timeout;
  logic               w_full, w_empty, w_push, w_pop, w_expire;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign pix_ready_o  = rst_i && !w_full;
  assign w_push       = pix_valid_i && pix_ready_o;
  assign w_pop        = (r_state == S_IDLE) && !w_empty && !r_gray_vld;
  assign w_expire     = (r_cnt == TW'(TIMEOUT));
  assign gray_valid_o = r_gray_vld;
  assign gray_data_o  = r_gray;
  assign timeout_o    = r_timeout;

  pixel_fifo #(.DEPTH(DEPTH), .W(PIX_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (pix_data_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    conv_start_o = 1'b0;
    conv_color_o = '0;
    case (r_state)
      S_IDLE:   if (w_pop) w_next = S_START;
      S_START: begin
        conv_start_o = 1'b1;
        w_next       = S_SEND_R;
      end
      S_SEND_R: begin
        conv_color_o = pix_byte(r_pix, R_MSB);
        w_next       = S_SEND_G;
      end
      S_SEND_G: begin
        conv_color_o = pix_byte(r_pix, G_MSB);
        w_next       = S_SEND_B;
      end
      S_SEND_B: begin
        conv_color_o = pix_byte(r_pix, B_MSB);
        w_next       = S_WAIT;
      end
      // A result arriving on the expiry cycle still counts.
      S_WAIT: begin
        if (conv_valid_i)  w_next = S_HOLD;
        else if (w_expire) w_next = S_IDLE;
      end
      S_HOLD:   if (gray_ready_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // r_cnt equals the number of cycles since the B byte while in WAIT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pix      <= '0;
      r_cnt      <= '0;
      r_gray     <= '0;
      r_gray_vld <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_pop) r_pix <= w_fifo_data;
      case (r_state)
        S_SEND_B: r_cnt <= TW'(1);
        S_WAIT: begin
          if (conv_valid_i) begin
            r_gray     <= conv_gray_i;
            r_gray_vld <= 1'b1;
          end else if (w_expire) begin
            r_timeout  <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        S_HOLD: if (gray_ready_i) r_gray_vld <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
